// File: rtl/spine_link_fifo.sv
// Elastic buffer for one inter-group spine link: absorbs valid-only bursts,
// drops and counts flits on overflow, and regenerates the destination address.
module spine_link_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  output logic [5:0]               out_dest_addr,
  input  logic                     out_ready,
  input  logic                     link_enable,
  input  logic                     clear_stats,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [CNT_W-1:0] dropCount_q, dropCount_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic pop;
  logic drop;

  // The output side only ever looks at registered state plus the link gate.
  assign out_valid     = !empty_q && link_enable;
  assign out_data      = mem[rdPtr_q];
  assign out_dest_addr = out_data[DWIDTH-1 -: 6];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full_q || pop);
  assign drop = in_valid && full_q && !pop;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // A clear beats a coincident drop for the counter, but the drop still marks overflow.
  always_comb begin
    dropCount_d = dropCount_q;
    overflow_d  = overflow_q;
    if (clear_stats) begin
      dropCount_d = '0;
      overflow_d  = drop;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (dropCount_q != {CNT_W{1'b1}}) begin
        dropCount_d = dropCount_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      dropCount_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      dropCount_q <= dropCount_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; reset blocks the write instead.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wrPtr_q] <= in_data;
    end
  end

  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign drop_count = dropCount_q;
  assign overflow   = overflow_q;

endmodule
